// File: rtl/axi_lite_pkg.sv
// Shared constants for the AXI4-Lite IP register block: response codes,
// register offsets and CTRL/STATUS bit positions.
package axi_lite_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // Register index taken from byte address bits [3:2]
  typedef enum logic [1:0] {
    RegCtrl    = 2'd0,
    RegDataIn  = 2'd1,
    RegStatus  = 2'd2,
    RegDataOut = 2'd3
  } reg_idx_e;

  localparam int unsigned CtrlStartBit      = 0;
  localparam int unsigned CtrlIrqEnBit      = 1;
  localparam int unsigned StatusBusyBit     = 0;
  localparam int unsigned StatusDoneBit     = 1;
  localparam int unsigned StatusStartErrBit = 2;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RespSlvErr : RespOkay;
  endfunction

endpackage

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite slave handshake engine: latches AW and W independently, issues a
// single-cycle write strobe once both are held, and returns a registered read.
module axi_lite_slave_if
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // AXI write address / data / response
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // AXI read address / data
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // Register-file side
  output logic                    wr_en_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [DATA_WIDTH-1:0]   wr_data_o,
  output logic [DATA_WIDTH/8-1:0] wr_strb_o,
  input  logic                    wr_err_i,
  output logic                    rd_en_o,
  output logic [ADDR_WIDTH-1:0]   rd_addr_o,
  input  logic [DATA_WIDTH-1:0]   rd_data_i,
  input  logic                    rd_err_i
);

  // Readies stay low while in reset and for the first cycle after its release
  logic                    ready_q;
  logic                    aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                    w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign s_axi_awready = ready_q & ~aw_full_q & ~bvalid_q;
  assign s_axi_wready  = ready_q & ~w_full_q & ~bvalid_q;
  assign s_axi_arready = ready_q & ~rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign b_hs  = bvalid_q & s_axi_bready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs  = rvalid_q & s_axi_rready;

  // bvalid gates the strobe so a held AW/W pair only updates registers once
  assign wr_en_o   = aw_full_q & w_full_q & ~bvalid_q;
  assign wr_addr_o = awaddr_q;
  assign wr_data_o = wdata_q;
  assign wr_strb_o = wstrb_q;

  // Read address goes straight to the register file; the result is captured below
  assign rd_en_o   = ar_hs;
  assign rd_addr_o = s_axi_araddr;

  // Next-state for the write latches, write response and read response
  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = s_axi_awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end
    if (wr_en_o) begin
      bvalid_d = 1'b1;
      bresp_d  = resp_of(wr_err_i);
    end
    if (b_hs) begin
      bvalid_d  = 1'b0;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_i;
      rresp_d  = resp_of(rd_err_i);
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  // Handshake state; reset aborts any transaction in flight without a response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      aw_full_q <= 1'b0;
      awaddr_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      ready_q   <= 1'b1;
      aw_full_q <= aw_full_d;
      awaddr_q  <= awaddr_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: rtl/axi_lite_ip_regs.sv
// AXI4-Lite register file in front of the latency-counted compute IP: turns a
// CTRL.START write into a one-cycle ip_enable, tracks busy/done, captures the
// result and drives a level interrupt on completion.
module axi_lite_ip_regs
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    ip_enable,
  output logic [DATA_WIDTH-1:0]   ip_data_in,
  input  logic                    ip_busy,
  input  logic [DATA_WIDTH-1:0]   ip_data_out,
  output logic                    irq
);

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_err;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_err;

  axi_lite_slave_if #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_slave_if (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .wr_strb_o    (wr_strb),
    .wr_err_i     (wr_err),
    .rd_en_o      (rd_en),
    .rd_addr_o    (rd_addr),
    .rd_data_i    (rd_data),
    .rd_err_i     (rd_err)
  );

  // Only the four word-aligned offsets 0x00..0x0C exist; all upper bits must be zero
  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> 4) == '0);
  endfunction

  logic                  irq_en_q, irq_en_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  done_q, done_d;
  logic                  start_err_q, start_err_d;
  logic                  busy_q;
  logic                  launch_q, launch_d;
  logic                  ip_enable_q, ip_enable_d;

  reg_idx_e wr_idx, rd_idx;
  logic     wr_ok, wr_lo;
  logic     ctrl_wr, din_wr, status_wr;
  logic     start_req, done_fall, busy_eff;

  assign wr_idx = reg_idx_e'(wr_addr[3:2]);
  assign rd_idx = reg_idx_e'(rd_addr[3:2]);
  assign wr_err = ~addr_hit(wr_addr);
  assign wr_ok  = wr_en & ~wr_err;
  // CTRL and STATUS only act when their single live byte is strobed
  assign wr_lo  = wr_strb[0];

  assign ctrl_wr   = wr_ok && (wr_idx == RegCtrl) && wr_lo;
  assign din_wr    = wr_ok && (wr_idx == RegDataIn);
  assign status_wr = wr_ok && (wr_idx == RegStatus) && wr_lo;
  assign start_req = ctrl_wr && wr_data[CtrlStartBit];

  // launch_q bridges the cycles between ip_enable and the IP reporting busy
  assign busy_eff  = ip_busy | launch_q;
  assign done_fall = busy_q & ~ip_busy;

  assign ip_enable  = ip_enable_q;
  assign ip_data_in = data_in_q;
  assign irq        = done_q & irq_en_q;

  // Register next-state: bus writes, start launch and completion capture
  always_comb begin
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      irq_en_d = wr_data[CtrlIrqEnBit];
    end

    data_in_d = data_in_q;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
      if (din_wr && wr_strb[b]) begin
        data_in_d[8*b +: 8] = wr_data[8*b +: 8];
      end
    end

    ip_enable_d = start_req & ~busy_eff;
    launch_d    = ip_enable_d | (launch_q & ~ip_busy);

    // Hardware set wins over a W1C clear landing in the same cycle
    start_err_d = (start_req & busy_eff) |
                  (start_err_q & ~(status_wr & wr_data[StatusStartErrBit]));
    done_d      = done_fall | (done_q & ~(status_wr & wr_data[StatusDoneBit]));
    data_out_d  = done_fall ? ip_data_out : data_out_q;
  end

  // Read mux; sees the current (pre-edge) register values
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd_en) begin
      if (!addr_hit(rd_addr)) begin
        rd_err = 1'b1;
      end else begin
        unique case (rd_idx)
          RegCtrl:    rd_data[CtrlIrqEnBit] = irq_en_q;
          RegDataIn:  rd_data = data_in_q;
          RegStatus: begin
            rd_data[StatusBusyBit]     = busy_eff;
            rd_data[StatusDoneBit]     = done_q;
            rd_data[StatusStartErrBit] = start_err_q;
          end
          RegDataOut: rd_data = data_out_q;
        endcase
      end
    end
  end

  // Register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q    <= 1'b0;
      data_in_q   <= '0;
      data_out_q  <= '0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      busy_q      <= 1'b0;
      launch_q    <= 1'b0;
      ip_enable_q <= 1'b0;
    end else begin
      irq_en_q    <= irq_en_d;
      data_in_q   <= data_in_d;
      data_out_q  <= data_out_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      busy_q      <= ip_busy;
      launch_q    <= launch_d;
      ip_enable_q <= ip_enable_d;
    end
  end

endmodule
